// File: rtl/seg_scan_controller.sv
// seg_scan_controller: 4-digit seven-segment scan with dead-time and blanking.
// Optional PWM dimming when SEG_SCAN_BRIGHTNESS_EN is defined.
module seg_scan_controller #(
  parameter int SCAN_DIV    = 100000,
  parameter int DEAD_CYCLES = 16,
  parameter int DIV_W       = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] blank_mask,
  input  logic [3:0] dp_mask,
  input  logic [1:0] bright,
  output logic [1:0] cnt,
  output logic [3:0] an,
  output logic       dp,
  output logic       slot_tick
);

  typedef enum logic {
    ST_DEAD,
    ST_ON
  } state_e;

  localparam logic [DIV_W-1:0] LAST =
    DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DEAD_V =
    DIV_W'(DEAD_CYCLES);
  localparam state_e ST_RST =
    (DEAD_CYCLES > 0) ? ST_DEAD : ST_ON;

  logic [DIV_W-1:0] sc_q, sc_d;
  logic [1:0]       cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic [1:0]       cnt_out_q, cnt_out_d;
  logic [3:0]       an_q, an_d;
  logic             dp_q, dp_d;
  logic             tick_q, tick_d;
  logic             pwm_ok;

`ifdef SEG_SCAN_BRIGHTNESS_EN
  localparam int LW = DIV_W + 2;
  localparam logic [LW-1:0] W_V =
    LW'(SCAN_DIV - DEAD_CYCLES);

  logic [1:0]    bright_q, bright_d;
  logic [1:0]    bright_s;
  logic [LW-1:0] limit;
  logic [LW-1:0] on_idx;

  // Dimming window: brightness captured at slot start
  always_comb begin
    bright_d = bright_q;
    if (en && sc_q == '0) bright_d = bright;
    bright_s = (sc_q == '0) ? bright : bright_q;
    limit    = ((LW'(bright_s) + LW'(1)) * W_V) >> 2;
    on_idx   = LW'(sc_q - DEAD_V);
    pwm_ok   = on_idx < limit;
  end

  // Brightness sample register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bright_q <= 2'd3;
    else        bright_q <= bright_d;
  end
`else
  logic unused_bright;
  assign unused_bright = ^bright;

  // Full ON phase when dimming is not built in
  always_comb begin
    pwm_ok = 1'b1;
  end
`endif

  // Slot counter, digit index and phase selection
  always_comb begin
    sc_d  = sc_q;
    cnt_d = cnt_q;
    if (!en) begin
      sc_d = '0;
    end else if (sc_q == LAST) begin
      sc_d  = '0;
      cnt_d = cnt_q + 2'd1;
    end else begin
      sc_d = sc_q + DIV_W'(1);
    end
    state_d = (sc_d < DEAD_V) ? ST_DEAD : ST_ON;
  end

  // Output decode from the current slot state
  always_comb begin
    an_d      = 4'b1111;
    dp_d      = 1'b1;
    tick_d    = en && (sc_q == LAST);
    cnt_out_d = cnt_q;
    if (en && state_q == ST_ON &&
        !blank_mask[cnt_q] && pwm_ok) begin
      an_d[cnt_q] = 1'b0;
      dp_d        = ~dp_mask[cnt_q];
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_q      <= '0;
      cnt_q     <= 2'd0;
      state_q   <= ST_RST;
      cnt_out_q <= 2'd0;
      an_q      <= 4'b1111;
      dp_q      <= 1'b1;
      tick_q    <= 1'b0;
    end else begin
      sc_q      <= sc_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      cnt_out_q <= cnt_out_d;
      an_q      <= an_d;
      dp_q      <= dp_d;
      tick_q    <= tick_d;
    end
  end

  assign cnt       = cnt_out_q;
  assign an        = an_q;
  assign dp        = dp_q;
  assign slot_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// tb_seg_scan_controller: directed tests, SCAN_DIV=8, DEAD_CYCLES=2.
// Expected values follow the slot/phase timing of the scan controller.
module tb_seg_scan_controller;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] blank_mask;
  logic [3:0] dp_mask;
  logic [1:0] bright;
  logic [1:0] cnt;
  logic [3:0] an;
  logic       dp;
  logic       slot_tick;

  int checks;
  int errors;

  seg_scan_controller #(
    .SCAN_DIV    (8),
    .DEAD_CYCLES (2),
    .DIV_W       (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .blank_mask (blank_mask),
    .dp_mask    (dp_mask),
    .bright     (bright),
    .cnt        (cnt),
    .an         (an),
    .dp         (dp),
    .slot_tick  (slot_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected anodes after edge k (k=1 is the first edge after release)
  function automatic logic [3:0] exp_an(int k, logic [3:0] blk);
    int pos;
    int d;
    logic [3:0] one;
    pos = (k - 1) % 8;
    d   = ((k - 1) / 8) % 4;
    one = 4'b0001;
    if (pos < 2 || blk[d]) return 4'b1111;
    return ~(one << d);
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    en         = 1'b0;
    blank_mask = 4'b0000;
    dp_mask    = 4'b0000;
    bright     = 2'd3;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    en         = 1'b1;
    blank_mask = 4'b0000;
    dp_mask    = 4'b1111;
    bright     = 2'd3;
    repeat (3) @(negedge clk);
    checks++;
    if (an !== 4'b1111) begin
      errors++;
      $display("FAIL reset_an got %b want 1111", an);
    end
    checks++;
    if (cnt !== 2'd0) begin
      errors++;
      $display("FAIL reset_cnt got %0d want 0", cnt);
    end
    checks++;
    if (dp !== 1'b1) begin
      errors++;
      $display("FAIL reset_dp got %b want 1", dp);
    end
    checks++;
    if (slot_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_tick got %b want 0", slot_tick);
    end
  endtask

  task automatic test_scan();
    logic [1:0] ec;
    logic       et;
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      step();
      ec = 2'(((k - 1) / 8) % 4);
      et = ((k - 1) % 8) == 7;
      checks++;
      if (an !== exp_an(k, 4'b0000)) begin
        errors++;
        $display("FAIL scan_an k=%0d got %b want %b",
                 k, an, exp_an(k, 4'b0000));
      end
      checks++;
      if (cnt !== ec) begin
        errors++;
        $display("FAIL scan_cnt k=%0d got %0d want %0d",
                 k, cnt, ec);
      end
      checks++;
      if (slot_tick !== et) begin
        errors++;
        $display("FAIL scan_tick k=%0d got %b want %b",
                 k, slot_tick, et);
      end
      checks++;
      if (dp !== 1'b1) begin
        errors++;
        $display("FAIL scan_dp k=%0d got %b want 1", k, dp);
      end
    end
  endtask

  task automatic test_blank();
    do_reset();
    blank_mask = 4'b0100;
    for (int k = 1; k <= 32; k++) begin
      step();
      checks++;
      if (an !== exp_an(k, 4'b0100)) begin
        errors++;
        $display("FAIL blank_an k=%0d got %b want %b",
                 k, an, exp_an(k, 4'b0100));
      end
    end
  endtask

  task automatic test_dp();
    logic ed;
    do_reset();
    dp_mask = 4'b0001;
    for (int k = 1; k <= 32; k++) begin
      step();
      ed = !(((k - 1) % 8) >= 2 && ((k - 1) / 8) % 4 == 0);
      checks++;
      if (dp !== ed) begin
        errors++;
        $display("FAIL dp k=%0d got %b want %b", k, dp, ed);
      end
    end
  endtask

  task automatic test_en_pause();
    logic [3:0] ea;
    do_reset();
    repeat (20) step();
    checks++;
    if (an !== 4'b1011 || cnt !== 2'd2) begin
      errors++;
      $display("FAIL pause_pre got an=%b cnt=%0d want 1011/2",
               an, cnt);
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (an !== 4'b1111 || cnt !== 2'd2 || slot_tick !== 1'b0) begin
        errors++;
        $display("FAIL pause_off i=%0d got an=%b cnt=%0d tick=%b want 1111/2/0",
                 i, an, cnt, slot_tick);
      end
    end
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      ea = (i < 2) ? 4'b1111 : 4'b1011;
      checks++;
      if (an !== ea || cnt !== 2'd2) begin
        errors++;
        $display("FAIL pause_resume i=%0d got an=%b cnt=%0d want %b/2",
                 i, an, cnt, ea);
      end
    end
    step();
    checks++;
    if (an !== 4'b1111 || cnt !== 2'd3) begin
      errors++;
      $display("FAIL pause_next got an=%b cnt=%0d want 1111/3",
               an, cnt);
    end
  endtask

  task automatic test_en_on_tick();
    logic [3:0] ea;
    do_reset();
    repeat (7) step();
    en = 1'b0;
    step();
    checks++;
    if (slot_tick !== 1'b0 || cnt !== 2'd0 || an !== 4'b1111) begin
      errors++;
      $display("FAIL tick_drop got tick=%b cnt=%0d an=%b want 0/0/1111",
               slot_tick, cnt, an);
    end
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      ea = (i < 2) ? 4'b1111 : 4'b1110;
      checks++;
      if (an !== ea || cnt !== 2'd0) begin
        errors++;
        $display("FAIL tick_resume i=%0d got an=%b cnt=%0d want %b/0",
                 i, an, cnt, ea);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (12) step();
    checks++;
    if (an !== 4'b1101 || cnt !== 2'd1) begin
      errors++;
      $display("FAIL arst_pre got an=%b cnt=%0d want 1101/1",
               an, cnt);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (an !== 4'b1111 || cnt !== 2'd0 || slot_tick !== 1'b0) begin
      errors++;
      $display("FAIL arst_now got an=%b cnt=%0d tick=%b want 1111/0/0",
               an, cnt, slot_tick);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_brightness();
    logic [3:0] ea;
    do_reset();
    bright = 2'd1;
    for (int k = 1; k <= 16; k++) begin
      step();
`ifdef SEG_SCAN_BRIGHTNESS_EN
      ea = ((k - 1) % 8 >= 2 && (k - 1) % 8 <= 4) ?
           exp_an(k, 4'b0000) : 4'b1111;
`else
      ea = exp_an(k, 4'b0000);
`endif
      checks++;
      if (an !== ea) begin
        errors++;
        $display("FAIL bright_an k=%0d got %b want %b", k, an, ea);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_scan();
    test_blank();
    test_dp();
    test_en_pause();
    test_en_on_tick();
    test_async_reset();
    test_brightness();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
